// File: rtl/mem_req_queue.sv
// -----------------------------------------------------------------------------
// mem_req_queue
//
// Buffers addresses coming from the CPU core and issues them one at a time to
// the memory controller. A small FIFO holds pending addresses; a two-state FSM
// drives a req/ack handshake towards memory and abandons any request that is
// not acknowledged within TIMEOUT cycles.
//
// Ports
//   clk          single clock, all state updates on the rising edge
//   rst          asynchronous, active-low reset
//   in_valid     upstream address valid
//   in_addr      upstream address
//   in_ready     FIFO can accept a push (= !full, from the registered count)
//   mem_req      request to the memory controller (high exactly while in REQ)
//   mem_addr     address presented with mem_req; holds its last value in IDLE
//   mem_ack      memory controller accepted the current request
//   done         one-cycle pulse after an acknowledged request
//   timeout_err  sticky flag: a request timed out and was dropped
//   err_clr      clears timeout_err (a new timeout on the same edge wins)
//   count        FIFO occupancy, not including the in-flight request
//   busy         FSM in REQ or FIFO non-empty
//   state_dbg    current FSM state (0 = IDLE, 1 = REQ)
//
// Handshakes
//   Upstream : a push happens on every rising edge where in_valid && in_ready.
//              in_valid/in_addr may change freely while in_ready is low; the
//              address is captured only on an edge where both are high.
//              in_ready ignores a pop on the same edge, so a full FIFO
//              refuses a push even when an entry leaves that edge.
//   Memory   : mem_req rises with mem_addr valid and both stay stable until
//              the edge where mem_ack is sampled high (or the timeout expires).
//              mem_ack is ignored whenever mem_req is low.
// -----------------------------------------------------------------------------
module mem_req_queue #(
  parameter int ADDR_W  = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [ADDR_W-1:0]        in_addr,
  output logic                     in_ready,
  output logic                     mem_req,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic                     mem_ack,
  output logic                     done,
  output logic                     timeout_err,
  input  logic                     err_clr,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     busy,
  output logic                     state_dbg
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int TIMER_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    fifo_q [DEPTH];
  logic [ADDR_W-1:0]    fifo_d [DEPTH];
  logic [PTR_W-1:0]     wptr_q, wptr_d;
  logic [PTR_W-1:0]     rptr_q, rptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 pop;
  logic                 set_err;

  // ---------------------------------------------------------------------------
  // FIFO control
  // ---------------------------------------------------------------------------
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = in_valid && !full;
  // The FSM only takes a new entry from IDLE, so a pop never overlaps REQ.
  assign pop   = (state_q == IDLE) && !empty;

  always_comb begin
    fifo_d  = fifo_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;

    if (push) begin
      fifo_d[wptr_q] = in_addr;
      wptr_d         = wptr_q + PTR_W'(1);
    end

    if (pop) begin
      rptr_d = rptr_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request FSM: next state and registered outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    mem_addr_d = mem_addr_q;
    done_d     = 1'b0;
    set_err    = 1'b0;

    case (state_q)
      IDLE: begin
        if (pop) begin
          mem_addr_d = fifo_q[rptr_q];
          timer_d    = '0;
          state_d    = REQ;
        end
      end

      REQ: begin
        // Ack is checked first so an ack on the final allowed cycle is a
        // success rather than a timeout.
        if (mem_ack) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (timer_q == TIMER_W'(TIMEOUT - 1)) begin
          state_d = IDLE;
          set_err = 1'b1;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // A fresh timeout outranks a clear arriving on the same edge.
  always_comb begin
    err_d = err_q;
    if (set_err) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      timer_q    <= '0;
      mem_addr_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      timer_q    <= timer_d;
      mem_addr_q <= mem_addr_d;
      done_q     <= done_d;
      err_q      <= err_d;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= fifo_d[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: all decoded from registers, so reset reaches them immediately.
  // ---------------------------------------------------------------------------
  assign in_ready    = !full;
  assign mem_req     = (state_q == REQ);
  assign mem_addr    = mem_addr_q;
  assign done        = done_q;
  assign timeout_err = err_q;
  assign count       = count_q;
  assign busy        = (state_q == REQ) || !empty;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_mem_req_queue.sv
// -----------------------------------------------------------------------------
// tb_mem_req_queue
//
// Two instances share the same stimulus: u_dut15 (TIMEOUT=15) and u_dut4
// (TIMEOUT=4). Each directed step checks only the instance it targets; both
// are reset between steps. The final step drives random traffic and compares
// u_dut15 cycle by cycle against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_mem_req_queue;

  // ---------------------------------------------------------------------------
  // Clock / reset / stimulus signals
  // ---------------------------------------------------------------------------
  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_addr;
  logic       mem_ack;
  logic       err_clr;

  logic       a_in_ready, a_mem_req, a_done, a_err, a_busy, a_state;
  logic [7:0] a_mem_addr;
  logic [2:0] a_count;

  logic       b_in_ready, b_mem_req, b_done, b_err, b_busy, b_state;
  logic [7:0] b_mem_addr;
  logic [2:0] b_count;

  int n_assert;
  int n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mem_req_queue #(.ADDR_W(8), .DEPTH(4), .TIMEOUT(15)) u_dut15 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_addr(in_addr), .in_ready(a_in_ready),
    .mem_req(a_mem_req), .mem_addr(a_mem_addr), .mem_ack(mem_ack),
    .done(a_done), .timeout_err(a_err), .err_clr(err_clr),
    .count(a_count), .busy(a_busy), .state_dbg(a_state)
  );

  mem_req_queue #(.ADDR_W(8), .DEPTH(4), .TIMEOUT(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_addr(in_addr), .in_ready(b_in_ready),
    .mem_req(b_mem_req), .mem_addr(b_mem_addr), .mem_ack(mem_ack),
    .done(b_done), .timeout_err(b_err), .err_clr(err_clr),
    .count(b_count), .busy(b_busy), .state_dbg(b_state)
  );

  // ---------------------------------------------------------------------------
  // Driver / checker tasks
  // ---------------------------------------------------------------------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Advance one clock; return 1 time unit after the edge so outputs are settled
  // and new inputs are set well before the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b0;
    in_valid = 1'b0;
    in_addr  = 8'h00;
    mem_ack  = 1'b0;
    err_clr  = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard / reference model state for the random step
  // ---------------------------------------------------------------------------
  logic [7:0] exp_q[$];
  logic       m_busy;
  logic [7:0] m_cur;
  int         m_age;
  logic       m_done;
  logic       m_issue;
  logic       acc;
  int         idx;
  int         issued;
  int         done_obs;
  int         cyc;

  initial begin
    n_assert = 0;
    n_fail   = 0;

    // ---- Reset values ------------------------------------------------------
    do_reset();
    chk("rst_count",    32'(a_count),    32'd0);
    chk("rst_in_ready", 32'(a_in_ready), 32'd1);
    chk("rst_mem_req",  32'(a_mem_req),  32'd0);
    chk("rst_mem_addr", 32'(a_mem_addr), 32'd0);
    chk("rst_done",     32'(a_done),     32'd0);
    chk("rst_err",      32'(a_err),      32'd0);
    chk("rst_busy",     32'(a_busy),     32'd0);
    chk("rst_state",    32'(a_state),    32'd0);

    // ---- 1: asynchronous reset during REQ ----------------------------------
    in_valid = 1'b1; in_addr = 8'h10; tick();
    in_addr = 8'h20; tick();
    in_addr = 8'h30; tick();
    in_valid = 1'b0;
    chk("t1_req_before_rst", 32'(a_mem_req), 32'd1);
    chk("t1_count_before",   32'(a_count),   32'd2);
    #2 rst = 1'b0;
    #1;
    chk("t1_async_mem_req",  32'(a_mem_req),  32'd0);
    chk("t1_async_count",    32'(a_count),    32'd0);
    chk("t1_async_in_ready", 32'(a_in_ready), 32'd1);
    chk("t1_async_done",     32'(a_done),     32'd0);
    chk("t1_async_busy",     32'(a_busy),     32'd0);
    #1 rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t1_no_req_after", 32'(a_mem_req), 32'd0);
    end

    // ---- 2: single request with ack held high ------------------------------
    do_reset();
    mem_ack = 1'b1; in_valid = 1'b1; in_addr = 8'h5A;
    tick();                                          // E0
    in_valid = 1'b0;
    chk("t2_e0_count",   32'(a_count),   32'd1);
    chk("t2_e0_mem_req", 32'(a_mem_req), 32'd0);
    tick();                                          // E1
    chk("t2_e1_mem_req",  32'(a_mem_req),  32'd1);
    chk("t2_e1_mem_addr", 32'(a_mem_addr), 32'h5A);
    chk("t2_e1_count",    32'(a_count),    32'd0);
    chk("t2_e1_busy",     32'(a_busy),     32'd1);
    tick();                                          // E2
    chk("t2_e2_mem_req", 32'(a_mem_req), 32'd0);
    chk("t2_e2_done",    32'(a_done),    32'd1);
    tick();                                          // E3
    chk("t2_e3_done",     32'(a_done),     32'd0);
    chk("t2_e3_busy",     32'(a_busy),     32'd0);
    chk("t2_e3_mem_addr", 32'(a_mem_addr), 32'h5A);
    mem_ack = 1'b0;

    // ---- 3: fill, refuse, then ordered drain -------------------------------
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      in_valid = 1'b1; in_addr = 8'(i);
      tick();
    end
    chk("t3_full_count",    32'(a_count),    32'd4);
    chk("t3_full_in_ready", 32'(a_in_ready), 32'd0);
    chk("t3_full_mem_addr", 32'(a_mem_addr), 32'h01);
    in_addr = 8'h06;
    tick();
    in_valid = 1'b0;
    chk("t3_refused_count", 32'(a_count), 32'd4);
    for (int k = 1; k <= 5; k++) begin
      chk("t3_req_high", 32'(a_mem_req),  32'd1);
      chk("t3_addr_seq", 32'(a_mem_addr), 32'(k));
      chk("t3_count",    32'(a_count),    32'(5 - k));
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      chk("t3_gap_low", 32'(a_mem_req), 32'd0);
      chk("t3_done",    32'(a_done),    32'd1);
      tick();
    end
    chk("t3_end_count",   32'(a_count),   32'd0);
    chk("t3_end_busy",    32'(a_busy),    32'd0);
    chk("t3_end_mem_req", 32'(a_mem_req), 32'd0);

    // ---- 4: timeout (TIMEOUT=4 instance) -----------------------------------
    do_reset();
    in_valid = 1'b1; in_addr = 8'h33; tick();
    in_valid = 1'b0; tick();
    for (int i = 0; i < 4; i++) begin
      chk("t4_req_window", 32'(b_mem_req), 32'd1);
      chk("t4_err_low",    32'(b_err),     32'd0);
      chk("t4_no_done",    32'(b_done),    32'd0);
      tick();
    end
    chk("t4_req_fell", 32'(b_mem_req), 32'd0);
    chk("t4_err_set",  32'(b_err),     32'd1);
    chk("t4_no_done2", 32'(b_done),    32'd0);
    in_valid = 1'b1; in_addr = 8'h44; tick();
    in_valid = 1'b0; tick();
    chk("t4_addr_44", 32'(b_mem_addr), 32'h44);
    mem_ack = 1'b1; tick();
    mem_ack = 1'b0;
    chk("t4_done_44",   32'(b_done), 32'd1);
    chk("t4_err_stick", 32'(b_err),  32'd1);
    err_clr = 1'b1; tick();
    err_clr = 1'b0;
    chk("t4_err_clr", 32'(b_err), 32'd0);

    // ---- 5a: ack on the last allowed REQ cycle -----------------------------
    do_reset();
    in_valid = 1'b1; in_addr = 8'h55; tick();
    in_valid = 1'b0; tick();
    tick(); tick(); tick();
    chk("t5a_req_4th", 32'(b_mem_req), 32'd1);
    mem_ack = 1'b1; tick();
    mem_ack = 1'b0;
    chk("t5a_done",    32'(b_done),    32'd1);
    chk("t5a_no_err",  32'(b_err),     32'd0);
    chk("t5a_req_low", 32'(b_mem_req), 32'd0);

    // ---- 5b: err_clr on the timeout edge -----------------------------------
    in_valid = 1'b1; in_addr = 8'h66; tick();
    in_valid = 1'b0; tick();
    tick(); tick(); tick();
    err_clr = 1'b1; tick();
    err_clr = 1'b0;
    chk("t5b_err_wins", 32'(b_err),     32'd1);
    chk("t5b_req_low",  32'(b_mem_req), 32'd0);
    chk("t5b_no_done",  32'(b_done),    32'd0);
    err_clr = 1'b1; tick();
    err_clr = 1'b0;
    chk("t5b_err_clr", 32'(b_err), 32'd0);

    // ---- 5c: full FIFO with push and pop on the same edge ------------------
    do_reset();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_addr = 8'h71 + 8'(i);
      mem_ack  = (i == 4);
      tick();
    end
    mem_ack = 1'b0;
    chk("t5c_full_count", 32'(b_count),    32'd4);
    chk("t5c_in_ready",   32'(b_in_ready), 32'd0);
    chk("t5c_ack_done",   32'(b_done),     32'd1);
    chk("t5c_ack_noerr",  32'(b_err),      32'd0);
    in_addr = 8'h76; tick();
    in_valid = 1'b0;
    chk("t5c_count_dm1", 32'(b_count),    32'd3);
    chk("t5c_popped",    32'(b_mem_addr), 32'h72);
    chk("t5c_req",       32'(b_mem_req),  32'd1);

    // ---- 6: random wrap-around against the reference model -----------------
    do_reset();
    exp_q.delete();
    m_busy = 1'b0; m_cur = 8'h00; m_age = 0; m_done = 1'b0;
    idx = 0; issued = 0; done_obs = 0; cyc = 0;
    while ((idx < 10 || exp_q.size() > 0 || m_busy) && cyc < 400) begin
      in_valid = (idx < 10) && ($urandom_range(0, 2) != 0);
      in_addr  = 8'hA0 + 8'(idx);
      // Random ack (also while idle, where it must be ignored); forced well
      // before the 15-cycle limit so no request is dropped.
      mem_ack  = ($urandom_range(0, 1) == 1) || (m_busy && m_age >= 8);
      acc      = in_valid && (exp_q.size() < 4);
      tick();

      m_done  = 1'b0;
      m_issue = 1'b0;
      if (m_busy) begin
        if (mem_ack) begin
          m_busy = 1'b0;
          m_done = 1'b1;
        end else if (m_age == 14) begin
          m_busy = 1'b0;
        end else begin
          m_age++;
        end
      end else if (exp_q.size() > 0) begin
        m_cur   = exp_q.pop_front();
        m_busy  = 1'b1;
        m_age   = 0;
        m_issue = 1'b1;
      end
      if (acc) begin
        exp_q.push_back(in_addr);
        idx++;
      end

      chk("t6_count",    32'(a_count),    32'(exp_q.size()));
      chk("t6_in_ready", 32'(a_in_ready), 32'(exp_q.size() < 4));
      chk("t6_mem_req",  32'(a_mem_req),  32'(m_busy));
      chk("t6_done",     32'(a_done),     32'(m_done));
      chk("t6_busy",     32'(a_busy),     32'(m_busy || exp_q.size() > 0));
      chk("t6_cnt_max",  32'(a_count <= 3'd4), 32'd1);
      if (m_busy) begin
        chk("t6_mem_addr", 32'(a_mem_addr), 32'(m_cur));
      end
      if (m_issue) begin
        chk("t6_issue_order", 32'(a_mem_addr), 32'hA0 + 32'(issued));
        issued++;
      end
      if (a_done) begin
        done_obs++;
      end
      cyc++;
    end
    chk("t6_complete",  32'(cyc < 400), 32'd1);
    chk("t6_issued",    32'(issued),    32'd10);
    chk("t6_done_cnt",  32'(done_obs),  32'd10);
    chk("t6_no_err",    32'(a_err),     32'd0);
    chk("t6_end_count", 32'(a_count),   32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
